instr_sequencer: RTL and testbench

- Multi-cycle instruction sequencer for the single-issue CPU datapath.
- Drives program-RAM fetch with a request/valid handshake and owns the program counter.
- Evaluates the 4-bit condition field against the ALU flags, handles branch and halt opcodes, and issues one-cycle strobes to the register file and ALU.

---
 rtl/instr_sequencer.sv | 161 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, fetches over a req/valid handshake,
// evaluates condition codes and issues one-cycle decode/execute/writeback strobes.
module instr_sequencer #(
  parameter int                ADDR_W     = 8,
  parameter int                INSTR_W    = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt_req,
  input  logic [INSTR_W-1:0] ram_rdata,
  input  logic               ram_rvalid,
  input  logic [3:0]         flags,
  output logic               ram_req,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               reg_load_en,
  output logic               alu_en,
  output logic               reg_wr_en,
  output logic               skipped,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [3:0] OP_BRANCH = 4'hF;
  localparam logic [3:0] OP_HALT   = 4'hE;

  state_t               st, st_nxt;
  logic [ADDR_W-1:0]    pc_nxt;
  logic [INSTR_W-1:0]   instr_nxt;
  logic                 halt_pend, halt_pend_nxt;
  logic [3:0]           cond, op;
  logic [ADDR_W-1:0]    target;
  logic                 flag_n, flag_z, flag_c, flag_v;
  logic                 cond_pass;

  assign cond     = instr[INSTR_W-1 -: 4];
  assign op       = instr[INSTR_W-5 -: 4];
  assign target   = instr[ADDR_W-1:0];
  assign {flag_n, flag_z, flag_c, flag_v} = flags;
  assign ram_addr = pc;
  assign state    = st;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = !flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = !flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = !flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = !flag_v;
      4'h8: cond_pass = flag_c && !flag_z;
      4'h9: cond_pass = !flag_c || flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = !flag_z && (flag_n == flag_v);
      4'hD: cond_pass = flag_z || (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    st_nxt        = st;
    pc_nxt        = pc;
    instr_nxt     = instr;
    halt_pend_nxt = halt_pend;
    ram_req       = 1'b0;
    reg_load_en   = 1'b0;
    alu_en        = 1'b0;
    reg_wr_en     = 1'b0;
    skipped       = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (st)
      S_IDLE: begin
        if (start) begin
          pc_nxt        = START_ADDR;
          halt_pend_nxt = 1'b0;
          st_nxt        = S_FETCH;
        end
      end
      S_FETCH: begin
        busy    = 1'b1;
        ram_req = 1'b1;
        if (ram_rvalid) begin
          instr_nxt = ram_rdata;
          pc_nxt    = pc + ADDR_W'(1);
          st_nxt    = S_DECODE;
        end
      end
      S_DECODE: begin
        busy        = 1'b1;
        reg_load_en = 1'b1;
        if (!cond_pass) begin
          skipped = 1'b1;
          st_nxt  = halt_pend ? S_HALT : S_FETCH;
        end else if (op == OP_BRANCH) begin
          pc_nxt = target;
          st_nxt = halt_pend ? S_HALT : S_FETCH;
        end else if (op == OP_HALT) begin
          st_nxt = S_HALT;
        end else begin
          st_nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        busy   = 1'b1;
        alu_en = 1'b1;
        st_nxt = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        busy      = 1'b1;
        reg_wr_en = 1'b1;
        st_nxt    = halt_pend ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        done = 1'b1;
        if (start) begin
          pc_nxt        = START_ADDR;
          halt_pend_nxt = 1'b0;
          st_nxt        = S_FETCH;
        end
      end
      default: st_nxt = S_IDLE;
    endcase
    // A request seen while busy waits for the next boundary; entering HALT consumes it.
    if (busy && halt_req) halt_pend_nxt = 1'b1;
    if (st_nxt == S_HALT && st != S_HALT) halt_pend_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      pc        <= START_ADDR;
      instr     <= '0;
      halt_pend <= 1'b0;
    end else begin
      st        <= st_nxt;
      pc        <= pc_nxt;
      instr     <= instr_nxt;
      halt_pend <= halt_pend_nxt;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: program-RAM responder with variable latency
// and an instruction-level reference model of fetch/decode/branch/halt behaviour.
module tb_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic [31:0] ram_rdata;
  logic        ram_rvalid;
  logic [3:0]  flags;
  logic        ram_req;
  logic [7:0]  ram_addr;
  logic [7:0]  pc;
  logic [31:0] instr;
  logic        reg_load_en;
  logic        alu_en;
  logic        reg_wr_en;
  logic        skipped;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] prog [256];
  int          lat;
  int          wait_cnt;
  logic        ram_en;
  logic        rsp_vld, frc_vld;
  logic [31:0] rsp_dat, frc_dat;

  assign ram_rvalid = ram_en ? rsp_vld : frc_vld;
  assign ram_rdata  = ram_en ? rsp_dat : frc_dat;

  instr_sequencer #(.ADDR_W(8), .INSTR_W(32), .START_ADDR(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid), .flags(flags),
    .ram_req(ram_req), .ram_addr(ram_addr), .pc(pc), .instr(instr),
    .reg_load_en(reg_load_en), .alu_en(alu_en), .reg_wr_en(reg_wr_en),
    .skipped(skipped), .busy(busy), .done(done), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program RAM: answers a held request after `lat` extra cycles (0 = same cycle).
  initial begin
    rsp_vld = 1'b0; rsp_dat = '0; wait_cnt = 0;
  end
  always @(negedge clk) begin
    if (ram_req && wait_cnt >= lat) begin
      rsp_vld = 1'b1; rsp_dat = prog[ram_addr]; wait_cnt = 0;
    end else if (ram_req) begin
      rsp_vld = 1'b0; wait_cnt++;
    end else begin
      rsp_vld = 1'b0; wait_cnt = 0;
    end
  end

  // Condition codes come in complementary pairs: odd code is the inverse of the even one.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; flags = 4'h0;
    ram_en = 1'b1; frc_vld = 1'b0; frc_dat = '0; lat = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_chk++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %0h expected 0", pc); end
    n_chk++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %0h expected 0", instr); end
    n_chk++; if ({ram_req, busy, done} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {ram_req, busy, done}); end
    n_chk++; if ({reg_load_en, alu_en, reg_wr_en, skipped} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {reg_load_en, alu_en, reg_wr_en, skipped}); end
  endtask

  task automatic test_alu_basic();
    logic [2:0] exp_s [5];
    int le, ae, we;
    exp_s = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    le = 0; ae = 0; we = 0;
    do_reset();
    prog[0] = {4'hE, 4'h1, 24'h123456};
    prog[1] = {4'hE, 4'h1, 24'h654321};
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (state !== exp_s[k]) begin n_fail++; $display("FAIL alu_state c%0d: got %0d expected %0d", k, state, exp_s[k]); end
      if (k == 1) begin
        n_chk++; if (pc !== 8'h01) begin n_fail++; $display("FAIL alu_pc: got %0h expected 1", pc); end
      end
      le += int'(reg_load_en); ae += int'(alu_en); we += int'(reg_wr_en);
      if (k < 4) tick();
    end
    n_chk++; if (le != 1 || ae != 1 || we != 1) begin
      n_fail++; $display("FAIL alu_strobe_counts: got %0d/%0d/%0d expected 1/1/1", le, ae, we); end
  endtask

  task automatic test_latency();
    int reqs;
    reqs = 0;
    do_reset();
    prog[0] = {4'hE, 4'h2, 24'hABCDEF};
    lat = 3;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_chk++; if ({ram_req, ram_addr} !== 9'h100) begin n_fail++; $display("FAIL lat_req c%0d: got %b/%0h expected 1/0", k, ram_req, ram_addr); end
      n_chk++; if (instr !== 32'h0) begin n_fail++; $display("FAIL lat_instr_early c%0d: got %0h expected 0", k, instr); end
      reqs += int'(ram_req);
      tick();
    end
    n_chk++; if (state !== 3'd2 || ram_req !== 1'b0) begin n_fail++; $display("FAIL lat_decode: got st%0d req%b expected st2 req0", state, ram_req); end
    n_chk++; if (instr !== prog[0]) begin n_fail++; $display("FAIL lat_instr: got %0h expected %0h", instr, prog[0]); end
    n_chk++; if (reqs != 4) begin n_fail++; $display("FAIL lat_req_cycles: got %0d expected 4", reqs); end
  endtask

  task automatic test_cond_sweep();
    logic pass;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      prog[i] = {iv[7:4], 4'h1, 16'($urandom), 8'($urandom)};
    end
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      n_chk++; if (state !== 3'd1 || ram_addr !== iv) begin n_fail++; $display("FAIL sweep_fetch i%0d: got st%0d addr %0h expected st1 addr %0h", i, state, ram_addr, iv); end
      flags = iv[3:0];
      tick();
      pass = ref_cond(iv[7:4], iv[3:0]);
      n_chk++; if (skipped !== !pass) begin n_fail++; $display("FAIL sweep_skip cond%0h flags%0h: got %b expected %b", iv[7:4], iv[3:0], skipped, !pass); end
      tick();
      n_chk++; if (alu_en !== pass) begin n_fail++; $display("FAIL sweep_alu cond%0h flags%0h: got %b expected %b", iv[7:4], iv[3:0], alu_en, pass); end
      if (pass) begin tick(); tick(); end
    end
    n_chk++; if (state !== 3'd1 || ram_addr !== 8'h00) begin n_fail++; $display("FAIL sweep_wrap: got st%0d addr %0h expected st1 addr 0", state, ram_addr); end
  endtask

  task automatic test_branch_halt();
    logic [7:0] hpc;
    do_reset();
    prog[8'h00] = {4'hE, 4'hF, 16'h0, 8'h10};
    prog[8'h10] = {4'hE, 4'hF, 16'h5A5A, 8'h40};
    prog[8'h40] = {4'hF, 4'hF, 16'h0, 8'h80};
    prog[8'h41] = {4'hE, 4'hE, 24'h0};
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    n_chk++; if (state !== 3'd1 || ram_addr !== 8'h10) begin n_fail++; $display("FAIL br_first: got st%0d addr %0h expected st1 addr 10", state, ram_addr); end
    tick(); tick();
    n_chk++; if (state !== 3'd1 || ram_addr !== 8'h40) begin n_fail++; $display("FAIL br_taken: got st%0d addr %0h expected st1 addr 40", state, ram_addr); end
    tick(); tick();
    n_chk++; if (state !== 3'd1 || ram_addr !== 8'h41) begin n_fail++; $display("FAIL br_never: got st%0d addr %0h expected st1 addr 41", state, ram_addr); end
    tick(); tick();
    n_chk++; if (state !== 3'd5 || done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL halt_op: got st%0d done%b busy%b expected st5 done1 busy0", state, done, busy); end
    hpc = pc;
    n_chk++; if (hpc !== 8'h42) begin n_fail++; $display("FAIL halt_pc: got %0h expected 42", hpc); end
    repeat (3) tick();
    n_chk++; if (pc !== 8'h42 || state !== 3'd5) begin n_fail++; $display("FAIL halt_hold: got pc %0h st%0d expected 42 st5", pc, state); end
    start = 1'b1; tick(); start = 1'b0;
    n_chk++; if (state !== 3'd1 || ram_addr !== 8'h00) begin n_fail++; $display("FAIL halt_restart: got st%0d addr %0h expected st1 addr 0", state, ram_addr); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    prog[8'h00] = {4'hE, 4'hF, 16'h0, 8'hFF};
    prog[8'hFF] = {4'hE, 4'h3, 24'h777777};
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    n_chk++; if (ram_addr !== 8'hFF) begin n_fail++; $display("FAIL wrap_fetch: got %0h expected ff", ram_addr); end
    tick();
    n_chk++; if (pc !== 8'h00 || state !== 3'd2) begin n_fail++; $display("FAIL wrap_pc: got %0h st%0d expected 0 st2", pc, state); end
    tick(); tick(); tick();
    n_chk++; if (state !== 3'd1 || ram_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_next: got st%0d addr %0h expected st1 addr 0", state, ram_addr); end
  endtask

  task automatic test_halt_req();
    int k;
    do_reset();
    for (int i = 0; i < 256; i++) prog[i] = {4'hE, 4'h1, 24'(i)};
    start = 1'b1; tick(); start = 1'b0;
    k = 0;
    while (state !== 3'd3 && k < 20) begin tick(); k++; end
    n_chk++; if (state !== 3'd3) begin n_fail++; $display("FAIL hreq_wait_exec: got st%0d expected 3 within 20 cycles", state); end
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    n_chk++; if (state !== 3'd4 || reg_wr_en !== 1'b1) begin n_fail++; $display("FAIL hreq_wb: got st%0d wr%b expected st4 wr1", state, reg_wr_en); end
    tick();
    n_chk++; if (state !== 3'd5 || done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL hreq_halt: got st%0d done%b busy%b expected st5 1 0", state, done, busy); end
    n_chk++; if (pc !== 8'h01) begin n_fail++; $display("FAIL hreq_pc: got %0h expected 1", pc); end
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    n_chk++; if (state !== 3'd1 || ram_addr !== 8'h01) begin n_fail++; $display("FAIL hreq_cleared: got st%0d addr %0h expected st1 addr 1", state, ram_addr); end
  endtask

  // Random programs with random RAM latency, flags and ignored start pulses.
  task automatic test_random_program();
    logic [7:0]  m_pc;
    logic [31:0] w;
    logic [3:0]  op;
    logic        pass;
    int          cur_lat;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      op = 4'($urandom);
      if (op == 4'hE) op = 4'h3;
      prog[i] = {4'($urandom), op, 24'($urandom)};
    end
    m_pc = 8'h00;
    lat = $urandom_range(0, 2); cur_lat = lat;
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 300; n++) begin
      flags = 4'($urandom);
      for (int k = 0; k <= cur_lat; k++) begin
        n_chk++; if (state !== 3'd1 || ram_addr !== m_pc) begin n_fail++; $display("FAIL rnd_fetch n%0d: got st%0d addr %0h expected st1 addr %0h", n, state, ram_addr, m_pc); end
        start = ($urandom_range(0, 3) == 0);
        tick();
      end
      w = prog[m_pc];
      pass = ref_cond(w[31:28], flags);
      n_chk++; if (state !== 3'd2 || skipped !== !pass || pc !== m_pc + 8'd1) begin
        n_fail++; $display("FAIL rnd_decode n%0d: got st%0d skip%b pc %0h expected st2 skip%b pc %0h", n, state, skipped, pc, !pass, m_pc + 8'd1); end
      m_pc = (pass && w[27:24] == 4'hF) ? w[7:0] : m_pc + 8'd1;
      if (pass && w[27:24] != 4'hF) begin
        start = ($urandom_range(0, 3) == 0);
        tick();
        n_chk++; if (state !== 3'd3 || alu_en !== 1'b1) begin n_fail++; $display("FAIL rnd_exec n%0d: got st%0d alu%b expected st3 alu1", n, state, alu_en); end
        tick();
        n_chk++; if (state !== 3'd4 || reg_wr_en !== 1'b1) begin n_fail++; $display("FAIL rnd_wb n%0d: got st%0d wr%b expected st4 wr1", n, state, reg_wr_en); end
      end
      lat = $urandom_range(0, 2); cur_lat = lat;
      start = ($urandom_range(0, 3) == 0);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] late;
    n_chk++; if (state !== 3'd1) begin n_fail++; $display("FAIL rmid_pre: got st%0d expected 1", state); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (state !== 3'd0 || pc !== 8'h00 || instr !== 32'h0) begin n_fail++; $display("FAIL rmid_async: got st%0d pc %0h instr %0h expected 0/0/0", state, pc, instr); end
    n_chk++; if ({ram_req, busy, done, reg_load_en, alu_en, reg_wr_en, skipped} !== 7'b0) begin
      n_fail++; $display("FAIL rmid_outs: got %b expected 0000000", {ram_req, busy, done, reg_load_en, alu_en, reg_wr_en, skipped}); end
    late = $urandom | 32'h1;
    ram_en = 1'b0; frc_vld = 1'b1; frc_dat = late;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    n_chk++; if (state !== 3'd0 || instr !== 32'h0 || pc !== 8'h00) begin n_fail++; $display("FAIL rmid_late_rvalid: got st%0d instr %0h pc %0h expected 0/0/0", state, instr, pc); end
    frc_vld = 1'b0; ram_en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = '0;
    test_reset();
    test_alu_basic();
    test_latency();
    test_cond_sweep();
    test_branch_halt();
    test_pc_wrap();
    test_halt_req();
    test_random_program();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
